measure_sequencer: RTL and testbench

Controller that sequences the latency-measurement datapath. It aligns each measurement to a video frame start and drives the flash stimulus. It generates the `reset_counter`, `sensor_trigger` and `reset_bcdoutput` strobes consumed by `measure`, debouncing the photo sensor and enforcing timeout and hold-off between samples. It sits between the video timing generator, the config register block and `measure`.

---
 rtl/measure_sequencer_if.sv | 34 +++
 rtl/measure_sequencer.sv | 136 +++++++++++++
 tb/tb_measure_sequencer.sv | 449 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/measure_sequencer_if.sv
// Signal bundle between the measurement sequencer and its environment:
// timing/config/sensor inputs and the strobes consumed by measure.
interface measure_sequencer_if;
    logic        enable;
    logic [7:0]  config_data;
    logic        frame_start;
    logic        sensor_in;
    logic        flash_on;
    logic        reset_counter;
    logic        sensor_trigger;
    logic        reset_bcdoutput;
    logic        timeout;
    logic        busy;
    logic [15:0] sample_count;
    logic [1:0]  state;

    modport master (
        output enable, config_data,
        output frame_start, sensor_in,
        input  flash_on, reset_counter,
        input  sensor_trigger, reset_bcdoutput,
        input  timeout, busy,
        input  sample_count, state
    );

    modport slave (
        input  enable, config_data,
        input  frame_start, sensor_in,
        output flash_on, reset_counter,
        output sensor_trigger, reset_bcdoutput,
        output timeout, busy,
        output sample_count, state
    );
endinterface

// File: rtl/measure_sequencer.sv
// Latency-measurement sequencer: frame-aligned flash stimulus, debounced
// photo sensor, timeout and hold-off between samples.
module measure_sequencer #(
    parameter int unsigned DEBOUNCE_CYCLES = 27,
    parameter int unsigned TIMEOUT_CYCLES  = 13500000,
    parameter int unsigned HOLDOFF_CYCLES  = 2700000,
    parameter int unsigned CNT_BITS        = 25
) (
    input  logic               clock,
    input  logic               reset,
    measure_sequencer_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARM     = 2'd1,
        MEASURE = 2'd2,
        HOLDOFF = 2'd3
    } state_t;

    localparam int unsigned DB_BITS = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DB_BITS-1:0] DB_MAX =
        DB_BITS'(DEBOUNCE_CYCLES);
    localparam logic [DB_BITS-1:0] DB_LAST =
        DB_BITS'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_BITS-1:0] TO_LAST =
        CNT_BITS'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_BITS-1:0] HO_LAST =
        CNT_BITS'(HOLDOFF_CYCLES - 1);

    state_t              fsm;
    state_t              nxt;
    logic [DB_BITS-1:0]  hi_cnt;
    logic [DB_BITS-1:0]  lo_cnt;
    logic                sensor_hi;
    logic                sensor_lo;
    logic [CNT_BITS-1:0] timer;
    logic [7:0]          cfg_q;
    logic                cfg_change;
    logic                rise;
    logic                go_meas;
    logic                hit;
    logic                expire;

    assign cfg_change = cfg_q != bus.config_data;
    assign bus.state  = fsm;

    // Rise = the sample that brings the high run to DEBOUNCE_CYCLES
    assign rise = bus.sensor_in && !sensor_hi
               && (hi_cnt == DB_LAST);

    always_comb begin
        nxt     = fsm;
        go_meas = 1'b0;
        hit     = 1'b0;
        expire  = 1'b0;
        if (cfg_change || !bus.enable) begin
            nxt = IDLE;
        end else begin
            unique case (fsm)
                IDLE: nxt = ARM;
                ARM: begin
                    if (bus.frame_start && sensor_lo) begin
                        nxt     = MEASURE;
                        go_meas = 1'b1;
                    end
                end
                MEASURE: begin
                    if (rise) begin
                        nxt = HOLDOFF;
                        hit = 1'b1;
                    end else if (timer == TO_LAST) begin
                        nxt    = HOLDOFF;
                        expire = 1'b1;
                    end
                end
                HOLDOFF: begin
                    if (timer == HO_LAST && sensor_lo)
                        nxt = ARM;
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            fsm                 <= IDLE;
            hi_cnt              <= '0;
            lo_cnt              <= '0;
            sensor_hi           <= 1'b0;
            sensor_lo           <= 1'b0;
            timer               <= '0;
            cfg_q               <= bus.config_data;
            bus.flash_on        <= 1'b0;
            bus.busy            <= 1'b0;
            bus.reset_counter   <= 1'b0;
            bus.sensor_trigger  <= 1'b0;
            bus.timeout         <= 1'b0;
            bus.reset_bcdoutput <= 1'b0;
            bus.sample_count    <= '0;
        end else begin
            cfg_q <= bus.config_data;

            if (!bus.sensor_in)
                hi_cnt <= '0;
            else if (hi_cnt != DB_MAX)
                hi_cnt <= hi_cnt + 1'b1;
            if (bus.sensor_in)
                lo_cnt <= '0;
            else if (lo_cnt != DB_MAX)
                lo_cnt <= lo_cnt + 1'b1;
            sensor_hi <= bus.sensor_in && (hi_cnt >= DB_LAST);
            sensor_lo <= !bus.sensor_in && (lo_cnt >= DB_LAST);

            fsm                 <= nxt;
            bus.flash_on        <= nxt == MEASURE;
            bus.busy            <= nxt == MEASURE || nxt == HOLDOFF;
            bus.reset_counter   <= go_meas;
            bus.sensor_trigger  <= hit;
            bus.timeout         <= expire;
            bus.reset_bcdoutput <= cfg_change;

            if (cfg_change)
                bus.sample_count <= '0;
            else if (hit)
                bus.sample_count <= bus.sample_count + 16'd1;

            // One timer serves both MEASURE and HOLDOFF; it saturates in HOLDOFF
            if (nxt != fsm)
                timer <= '0;
            else if (fsm == MEASURE)
                timer <= timer + 1'b1;
            else if (fsm == HOLDOFF && timer != HO_LAST)
                timer <= timer + 1'b1;
        end
    end
endmodule

// File: tb/tb_measure_sequencer.sv
// Self-checking bench for measure_sequencer: directed scenarios plus
// randomized stimulus against a cycle-count reference model.
module tb_measure_sequencer;
    localparam int D = 4;
    localparam int T = 100;
    localparam int H = 20;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic preload_req = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;

    measure_sequencer_if sif();

    measure_sequencer #(
        .DEBOUNCE_CYCLES(D),
        .TIMEOUT_CYCLES (T),
        .HOLDOFF_CYCLES (H),
        .CNT_BITS       (8)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (sif)
    );

    always #5 clock = ~clock;

    // Reference model: run lengths of sensor levels and the edge index at
    // which the current phase began (0 IDLE, 1 ARM, 2 MEASURE, 3 HOLDOFF).
    logic [1:0]  m_state = 2'd0;
    logic        m_flash = 1'b0;
    logic        m_rc = 1'b0;
    logic        m_trig = 1'b0;
    logic        m_rbcd = 1'b0;
    logic        m_to = 1'b0;
    logic        m_busy = 1'b0;
    logic [15:0] m_cnt = 16'd0;
    logic [7:0]  m_cfg = 8'd0;
    int          run_hi = 0;
    int          run_lo = 0;
    int          t_enter = 0;
    int          now = 0;

    always @(posedge clock) begin : ref_model
        int hi, lo, te;
        logic [1:0] ph;
        logic rc, tr, rb, to, lo_ok, rise;
        logic [15:0] cnt;
        hi = sif.sensor_in ? run_hi + 1 : 0;
        lo = sif.sensor_in ? 0 : run_lo + 1;
        if (hi > D + 1) hi = D + 1;
        if (lo > D + 1) lo = D + 1;
        lo_ok = run_lo >= D;
        rise = hi == D;
        ph = m_state;
        cnt = preload_req ? 16'hFFFF : m_cnt;
        te = t_enter;
        rc = 1'b0;
        tr = 1'b0;
        rb = 1'b0;
        to = 1'b0;
        if (reset) begin
            ph = 2'd0;
            cnt = 16'd0;
            hi = 0;
            lo = 0;
        end else if (sif.config_data != m_cfg) begin
            rb = 1'b1;
            cnt = 16'd0;
            ph = 2'd0;
        end else if (!sif.enable) begin
            ph = 2'd0;
        end else begin
            case (ph)
                2'd0: ph = 2'd1;
                2'd1: if (sif.frame_start && lo_ok) begin
                    ph = 2'd2;
                    rc = 1'b1;
                    te = now;
                end
                2'd2: if (rise) begin
                    tr = 1'b1;
                    cnt = cnt + 16'd1;
                    ph = 2'd3;
                    te = now;
                end else if (now - t_enter == T) begin
                    to = 1'b1;
                    ph = 2'd3;
                    te = now;
                end
                default: if (now - t_enter >= H && lo_ok) ph = 2'd1;
            endcase
        end
        run_hi  <= hi;
        run_lo  <= lo;
        m_cfg   <= sif.config_data;
        m_state <= ph;
        m_flash <= ph == 2'd2;
        m_busy  <= ph >= 2'd2;
        m_rc    <= rc;
        m_trig  <= tr;
        m_rbcd  <= rb;
        m_to    <= to;
        m_cnt   <= cnt;
        t_enter <= te;
        now     <= now + 1;
    end

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clock);
        n_checks++;
        if ({sif.flash_on, sif.reset_counter, sif.sensor_trigger,
             sif.reset_bcdoutput, sif.timeout, sif.busy} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_strobes: got %b expected 000000",
                {sif.flash_on, sif.reset_counter, sif.sensor_trigger,
                 sif.reset_bcdoutput, sif.timeout, sif.busy});
        end
        n_checks++;
        if (sif.sample_count !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_count: got %0d expected 0",
                sif.sample_count);
        end
        n_checks++;
        if (sif.state !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_state: got %0d expected 0", sif.state);
        end
        reset = 1'b0;
        @(negedge clock);
        n_checks++;
        if (sif.reset_bcdoutput !== 1'b0 || sif.state !== 2'd0) begin
            n_fail++;
            $display("FAIL post_reset: got rbcd=%b state=%0d expected 0/0",
                sif.reset_bcdoutput, sif.state);
        end
    endtask

    task automatic test_normal();
        int lat, hold, rc_extra;
        sif.enable = 1'b1;
        repeat (D + 2) @(negedge clock);
        n_checks++;
        if (sif.state !== 2'd1) begin
            n_fail++;
            $display("FAIL arm_from_idle: got %0d expected 1", sif.state);
        end
        sif.frame_start = 1'b1;
        @(negedge clock);
        sif.frame_start = 1'b0;
        n_checks++;
        if ({sif.reset_counter, sif.state, sif.flash_on, sif.busy}
            !== 5'b11011) begin
            n_fail++;
            $display("FAIL measure_entry: got rc=%b st=%0d fl=%b expected 1/2/1",
                sif.reset_counter, sif.state, sif.flash_on);
        end
        lat = 0;
        rc_extra = 0;
        while (sif.sensor_trigger !== 1'b1 && lat < 200) begin
            @(negedge clock);
            lat++;
            rc_extra += int'(sif.reset_counter);
            if (lat == 30) sif.sensor_in = 1'b1;
        end
        n_checks++;
        if (lat != 30 + D || rc_extra != 0) begin
            n_fail++;
            $display("FAIL trigger_latency: got %0d rc_extra=%0d expected %0d/0",
                lat, rc_extra, 30 + D);
        end
        n_checks++;
        if (sif.state !== 2'd3 || sif.flash_on !== 1'b0 ||
            sif.sample_count !== 16'd1) begin
            n_fail++;
            $display("FAIL trigger_state: got st=%0d fl=%b cnt=%0d expected 3/0/1",
                sif.state, sif.flash_on, sif.sample_count);
        end
        sif.sensor_in = 1'b0;
        hold = 0;
        while (sif.state !== 2'd1 && hold < 200) begin
            @(negedge clock);
            hold++;
        end
        n_checks++;
        if (hold != H) begin
            n_fail++;
            $display("FAIL holdoff_len: got %0d expected %0d", hold, H);
        end
    endtask

    task automatic test_timeout();
        int t, trig_seen;
        sif.frame_start = 1'b1;
        @(negedge clock);
        sif.frame_start = 1'b0;
        t = 0;
        trig_seen = 0;
        while (sif.timeout !== 1'b1 && t < 300) begin
            @(negedge clock);
            t++;
            trig_seen += int'(sif.sensor_trigger);
        end
        n_checks++;
        if (t != T) begin
            n_fail++;
            $display("FAIL timeout_latency: got %0d expected %0d", t, T);
        end
        n_checks++;
        if (trig_seen != 0 || sif.sample_count !== 16'd1 ||
            sif.state !== 2'd3) begin
            n_fail++;
            $display("FAIL timeout_side: got trig=%0d cnt=%0d st=%0d expected 0/1/3",
                trig_seen, sif.sample_count, sif.state);
        end
        t = 0;
        while (sif.state !== 2'd1 && t < 100) begin
            @(negedge clock);
            t++;
        end
        n_checks++;
        if (sif.state !== 2'd1) begin
            n_fail++;
            $display("FAIL rearm_after_timeout: got %0d expected 1",
                sif.state);
        end
    endtask

    task automatic test_glitch();
        int ntrig;
        sif.frame_start = 1'b1;
        @(negedge clock);
        sif.frame_start = 1'b0;
        ntrig = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clock);
            ntrig += int'(sif.sensor_trigger);
            sif.sensor_in = (i >= 3 && i < 6) || (i >= 11 && i < 15);
        end
        n_checks++;
        if (ntrig != 1 || sif.sample_count !== 16'd2) begin
            n_fail++;
            $display("FAIL glitch_reject: got trig=%0d cnt=%0d expected 1/2",
                ntrig, sif.sample_count);
        end
        ntrig = 0;
        while (sif.state !== 2'd1 && ntrig < 100) begin
            @(negedge clock);
            ntrig++;
        end
    endtask

    task automatic test_config();
        sif.frame_start = 1'b1;
        @(negedge clock);
        sif.frame_start = 1'b0;
        repeat (5) @(negedge clock);
        sif.sensor_in = 1'b1;
        repeat (3) @(negedge clock);
        sif.config_data = 8'h34;
        @(negedge clock);
        n_checks++;
        if ({sif.reset_bcdoutput, sif.sensor_trigger, sif.flash_on}
            !== 3'b100 || sif.sample_count !== 16'd0 ||
            sif.state !== 2'd0) begin
            n_fail++;
            $display("FAIL config_abort: got rb=%b tr=%b fl=%b cnt=%0d st=%0d expected 1/0/0/0/0",
                sif.reset_bcdoutput, sif.sensor_trigger, sif.flash_on,
                sif.sample_count, sif.state);
        end
        @(negedge clock);
        sif.sensor_in = 1'b0;
        n_checks++;
        if (sif.reset_bcdoutput !== 1'b0 || sif.state !== 2'd1 ||
            sif.sensor_trigger !== 1'b0) begin
            n_fail++;
            $display("FAIL config_rearm: got rb=%b st=%0d tr=%b expected 0/1/0",
                sif.reset_bcdoutput, sif.state, sif.sensor_trigger);
        end
    endtask

    task automatic test_stuck_high();
        int k;
        repeat (D + 1) @(negedge clock);
        sif.frame_start = 1'b1;
        @(negedge clock);
        sif.frame_start = 1'b0;
        sif.sensor_in = 1'b1;
        k = 0;
        while (sif.sensor_trigger !== 1'b1 && k < 20) begin
            @(negedge clock);
            k++;
        end
        for (int i = 0; i < H + 10; i++) begin
            @(negedge clock);
            sif.frame_start = i == 15;
        end
        sif.frame_start = 1'b0;
        n_checks++;
        if (sif.state !== 2'd3 || sif.sample_count !== 16'd1) begin
            n_fail++;
            $display("FAIL stuck_holdoff: got st=%0d cnt=%0d expected 3/1",
                sif.state, sif.sample_count);
        end
        sif.sensor_in = 1'b0;
        k = 0;
        while (sif.state !== 2'd1 && k < 50) begin
            @(negedge clock);
            k++;
        end
        n_checks++;
        if (k != D + 1) begin
            n_fail++;
            $display("FAIL stuck_rearm: got %0d expected %0d", k, D + 1);
        end
        sif.sensor_in = 1'b1;
        @(negedge clock);
        sif.frame_start = 1'b1;
        @(negedge clock);
        sif.frame_start = 1'b0;
        n_checks++;
        if (sif.state !== 2'd1 || sif.reset_counter !== 1'b0) begin
            n_fail++;
            $display("FAIL frame_ignored: got st=%0d rc=%b expected 1/0",
                sif.state, sif.reset_counter);
        end
        sif.sensor_in = 1'b0;
    endtask

    task automatic test_wrap_reset();
        int k;
        repeat (D + 1) @(negedge clock);
        sif.frame_start = 1'b1;
        @(negedge clock);
        sif.frame_start = 1'b0;
        force sif.sample_count = 16'hFFFF;
        preload_req = 1'b1;
        #1 release sif.sample_count;
        @(negedge clock);
        preload_req = 1'b0;
        sif.sensor_in = 1'b1;
        k = 0;
        while (sif.sensor_trigger !== 1'b1 && k < 20) begin
            @(negedge clock);
            k++;
        end
        n_checks++;
        if (sif.sensor_trigger !== 1'b1 || sif.sample_count !== 16'd0) begin
            n_fail++;
            $display("FAIL count_wrap: got tr=%b cnt=%h expected 1/0000",
                sif.sensor_trigger, sif.sample_count);
        end
        sif.sensor_in = 1'b0;
        k = 0;
        while (sif.state !== 2'd1 && k < 100) begin
            @(negedge clock);
            k++;
        end
        sif.frame_start = 1'b1;
        @(negedge clock);
        sif.frame_start = 1'b0;
        repeat (3) @(negedge clock);
        n_checks++;
        if (sif.state !== 2'd2) begin
            n_fail++;
            $display("FAIL rearm_before_reset: got %0d expected 2", sif.state);
        end
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        n_checks++;
        if ({sif.flash_on, sif.reset_counter, sif.sensor_trigger,
             sif.reset_bcdoutput, sif.timeout, sif.busy} !== 6'b0 ||
            sif.sample_count !== 16'd0 || sif.state !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_mid_measure: got %b cnt=%0d st=%0d expected 000000/0/0",
                {sif.flash_on, sif.reset_counter, sif.sensor_trigger,
                 sif.reset_bcdoutput, sif.timeout, sif.busy},
                sif.sample_count, sif.state);
        end
    endtask

    task automatic test_random();
        int run_left;
        logic [23:0] got, exp;
        run_left = 0;
        sif.enable = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clock);
            got = {sif.state, sif.flash_on, sif.reset_counter,
                   sif.sensor_trigger, sif.reset_bcdoutput, sif.timeout,
                   sif.busy, sif.sample_count};
            exp = {m_state, m_flash, m_rc, m_trig, m_rbcd, m_to,
                   m_busy, m_cnt};
            n_checks++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL random_cycle_%0d: got %h expected %h",
                    i, got, exp);
            end
            reset = $urandom_range(0, 499) == 0;
            if (!sif.enable)
                sif.enable = $urandom_range(0, 9) == 0;
            else
                sif.enable = $urandom_range(0, 199) != 0;
            if ($urandom_range(0, 299) == 0)
                sif.config_data = 8'($urandom);
            sif.frame_start = $urandom_range(0, 11) == 0;
            if (run_left == 0) begin
                sif.sensor_in = ~sif.sensor_in;
                if (sif.sensor_in)
                    run_left = $urandom_range(1, 10);
                else if ($urandom_range(0, 9) == 0)
                    run_left = $urandom_range(80, 160);
                else
                    run_left = $urandom_range(1, 30);
            end
            run_left--;
        end
        reset = 1'b0;
    endtask

    initial begin
        sif.enable = 1'b0;
        sif.config_data = 8'h12;
        sif.frame_start = 1'b0;
        sif.sensor_in = 1'b0;
        test_reset();
        test_normal();
        test_timeout();
        test_glitch();
        test_config();
        test_stuck_high();
        test_wrap_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures",
            n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got no finish expected finish by 1ms");
        $fatal(1, "watchdog expired");
    end
endmodule
